stopwatch_key_ctrl: RTL

Controller between the PS/2 keyboard receiver and the stopwatch counter (clock_counter_top). It decodes PS/2 set-2 scan-code bytes into Start/Stop/Reset/Lap commands and runs the stopwatch state machine that drives the counter's is_start/is_stop/is_reset controls. It also captures lap times and selects the digits sent to the display.

---
 rtl/stopwatch_key_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/stopwatch_key_ctrl.sv
// Stopwatch keyboard controller: decodes PS/2 set-2 bytes into Start/Stop/Reset/Lap
// commands, runs the stopwatch state machine and selects the digits for the display.
module stopwatch_key_ctrl #(
    parameter logic [7:0] KEY_START = 8'h1B,
    parameter logic [7:0] KEY_STOP  = 8'h4D,
    parameter logic [7:0] KEY_RESET = 8'h2D,
    parameter logic [7:0] KEY_LAP   = 8'h4B
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [7:0]  key_code,
    input  logic [23:0] cnt_digits,
    output logic        is_start,
    output logic        is_stop,
    output logic        is_reset,
    output logic        lap_hold,
    output logic [23:0] disp_digits,
    output logic [1:0]  state_out
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        STOP = 2'b10
    } SwState;

    localparam logic [7:0] BREAK_PREFIX = 8'hF0;
    localparam logic [7:0] EXT_PREFIX   = 8'hE0;

    SwState      state;
    SwState      stateNext;
    logic        brkFlag;
    logic        extFlag;
    logic [7:0]  heldCode;
    logic        heldValid;
    logic [23:0] lapReg;
    logic [23:0] lapRegNext;
    logic        lapHoldNext;
    logic        resetPulseNext;
    logic        isCodeByte;
    logic        isRepeat;
    logic        isMake;
    logic        cmdStart;
    logic        cmdStop;
    logic        cmdReset;
    logic        cmdLap;

    assign isCodeByte = key_valid && (key_code != BREAK_PREFIX) && (key_code != EXT_PREFIX);
    assign isRepeat   = heldValid && (key_code == heldCode);
    assign isMake     = isCodeByte && !extFlag && !brkFlag && !isRepeat;
    assign cmdStart   = isMake && (key_code == KEY_START);
    assign cmdStop    = isMake && (key_code == KEY_STOP);
    assign cmdReset   = isMake && (key_code == KEY_RESET);
    assign cmdLap     = isMake && (key_code == KEY_LAP);

    // Prefix flags live only until the next code byte; the held key suppresses typematic repeats.
    always_ff @(posedge clock) begin
        if (reset) begin
            brkFlag   <= 1'b0;
            extFlag   <= 1'b0;
            heldCode  <= 8'h00;
            heldValid <= 1'b0;
        end else if (key_valid) begin
            if (key_code == BREAK_PREFIX) begin
                brkFlag <= 1'b1;
            end else if (key_code == EXT_PREFIX) begin
                extFlag <= 1'b1;
            end else begin
                brkFlag <= 1'b0;
                extFlag <= 1'b0;
                if (!extFlag) begin
                    if (brkFlag) begin
                        if (isRepeat) begin
                            heldValid <= 1'b0;
                        end
                    end else if (!isRepeat) begin
                        heldCode  <= key_code;
                        heldValid <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            lap_hold    <= 1'b0;
            lapReg      <= 24'h000000;
            is_start    <= 1'b0;
            is_stop     <= 1'b0;
            is_reset    <= 1'b0;
            disp_digits <= 24'h000000;
        end else begin
            state       <= stateNext;
            lap_hold    <= lapHoldNext;
            lapReg      <= lapRegNext;
            is_start    <= (stateNext == RUN);
            is_stop     <= (stateNext == STOP);
            is_reset    <= resetPulseNext;
            disp_digits <= lap_hold ? lapReg : cnt_digits;
        end
    end

    // Commands not listed for a state fall through to the hold defaults.
    always_comb begin
        stateNext      = state;
        lapHoldNext    = lap_hold;
        lapRegNext     = lapReg;
        resetPulseNext = 1'b0;
        case (state)
            IDLE: begin
                if (cmdStart) begin
                    stateNext = RUN;
                end else if (cmdReset) begin
                    resetPulseNext = 1'b1;
                    lapHoldNext    = 1'b0;
                end
            end
            RUN: begin
                if (cmdStop) begin
                    stateNext = STOP;
                end else if (cmdLap) begin
                    lapRegNext  = cnt_digits;
                    lapHoldNext = 1'b1;
                end
            end
            STOP: begin
                if (cmdStart) begin
                    stateNext = RUN;
                end else if (cmdReset) begin
                    stateNext      = IDLE;
                    resetPulseNext = 1'b1;
                    lapHoldNext    = 1'b0;
                end else if (cmdLap) begin
                    lapHoldNext = 1'b0;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign state_out = state;

endmodule
